newton_div_param: RTL and testbench

NEWTON_DIV_PARAM -- requirements
Module: newton_div_param

---
 rtl/newton_div_param.sv | 109 ++++++++++
 tb/tb_newton_div_param.sv | 128 ++++++++++++
 2 files changed

// File: rtl/newton_div_param.sv
// newton_div_param: iterative Newton-Raphson fractional divider q = a/b with a seeded reciprocal.
// Operands are normalised fractions 0.1xxx; the quotient carries one integer bit.
module newton_div_param #(
    parameter int W     = 32,
    parameter int ITERS = 3,
    parameter int CW    = ($clog2(ITERS + 1) > 1) ? $clog2(ITERS + 1) : 1
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          start,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    output logic [W-1:0]  q,
    output logic          busy,
    output logic          ready,
    output logic          dbz,
    output logic [CW-1:0] count
);
    typedef enum logic [1:0] {IDLE, ITER, ROUND, DONE} state_e;
    state_e          state_q;
    logic [W-1:0]    a_q, b_q, q_q;
    logic [W+1:0]    x_q, x_d, t;
    logic [W-1:0]    q_d;
    logic [CW-1:0]   count_q;
    logic            busy_q, ready_q, dbz_q;
    logic [7:0]      seed;
    logic [2*W+1:0]  p, r;
    logic [2*W+3:0]  xt;
    logic            unused_bits;
    always_comb begin
        seed = 8'h00;
        case (b[W-2:W-5])
            4'h0: seed = 8'hff;
            4'h1: seed = 8'hdf;
            4'h2: seed = 8'hc3;
            4'h3: seed = 8'haa;
            4'h4: seed = 8'h93;
            4'h5: seed = 8'h7f;
            4'h6: seed = 8'h6d;
            4'h7: seed = 8'h5c;
            4'h8: seed = 8'h4d;
            4'h9: seed = 8'h3f;
            4'ha: seed = 8'h33;
            4'hb: seed = 8'h27;
            4'hc: seed = 8'h1c;
            4'hd: seed = 8'h12;
            4'he: seed = 8'h08;
            default: seed = 8'h00;
        endcase
    end
    // x' = x*(2 - b*x); x is 2.W, t is 1.(W+1), so the product slice lands back in 2.W
    assign p   = {{(W+2){1'b0}}, b_q} * {{W{1'b0}}, x_q};
    assign t   = (W+2)'(0) - p[2*W:W-1];
    assign xt  = {{(W+2){1'b0}}, x_q} * {{(W+2){1'b0}}, t};
    assign x_d = xt[2*W+2:W+1];
    assign r   = {{(W+2){1'b0}}, a_q} * {{W{1'b0}}, x_q};
    assign q_d = r[2*W:W+1] + W'(|r[W:W-2]);
    assign unused_bits = ^{p[2*W+1], p[W-2:0], xt[2*W+3], xt[W:0], r[2*W+1], r[W-3:0]};
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            x_q     <= '0;
            q_q     <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: if (start) begin
                    count_q <= '0;
                    if (b[W-1]) begin
                        a_q     <= a;
                        b_q     <= b;
                        x_q     <= {2'b01, seed, {(W-8){1'b0}}};
                        ready_q <= 1'b0;
                        dbz_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ITER;
                    end else begin
                        q_q     <= '1;
                        ready_q <= 1'b1;
                        dbz_q   <= 1'b1;
                        state_q <= DONE;
                    end
                end
                ITER: begin
                    x_q     <= x_d;
                    count_q <= count_q + CW'(1);
                    if (count_q == CW'(ITERS - 1)) state_q <= ROUND;
                end
                ROUND: begin
                    q_q     <= q_d;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign q     = q_q;
    assign busy  = busy_q;
    assign ready = ready_q;
    assign dbz   = dbz_q;
    assign count = count_q;
endmodule

// File: tb/tb_newton_div_param.sv
// tb_newton_div_param: directed checks of the Newton divider (W=32, ITERS=3).
module tb_newton_div_param;
    logic        clk = 1'b0, clrn = 1'b1, start = 1'b0;
    logic [31:0] a = '0, b = '0, q;
    logic        busy, ready, dbz;
    logic [1:0]  count;
    int          checks = 0, failures = 0;
    int          lat, nb;
    logic        r0, d0, seen;
    logic [31:0] ra, rb;
    logic [63:0] ref_q;

    newton_div_param #(.W(32), .ITERS(3)) dut (
        .clk(clk), .clrn(clrn), .start(start), .a(a), .b(b),
        .q(q), .busy(busy), .ready(ready), .dbz(dbz), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_near(input string tag, input logic [31:0] obs, input logic [31:0] exp, input int tol);
        logic [31:0] d;
        d = (obs > exp) ? obs - exp : exp - obs;
        checks++;
        assert (d <= 32'(tol)) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h+/-%0d", tag, obs, exp, tol);
        end
    endtask

    // lat: edges after the accepting edge until ready; nb: busy samples seen meanwhile
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                          output int olat, output int onb, output logic ordy, output logic odbz);
        @(negedge clk);
        a = ta; b = tb_v; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        ordy = ready; odbz = dbz; olat = 0; onb = int'(busy);
        while (ready !== 1'b1 && olat < 20) begin
            @(posedge clk);
            #1 olat++;
            onb += int'(busy);
        end
    endtask

    initial begin
        #2 clrn = 1'b0;
        #1;
        chk("rst_q", q, 0); chk("rst_busy", busy, 0); chk("rst_ready", ready, 0);
        chk("rst_dbz", dbz, 0); chk("rst_count", count, 0);
        @(negedge clk) clrn = 1'b1;

        run_op(32'h80000000, 32'h80000000, lat, nb, r0, d0);
        chk("one_lat", lat, 4); chk("one_busy_cycles", nb, 4); chk("one_acc_ready", r0, 0);
        chk("one_q", q, 32'h80000000); chk("one_dbz", dbz, 0); chk("one_count", count, 3);
        chk("one_busy_end", busy, 0);
        repeat (3) @(negedge clk);
        chk("hold_q", q, 32'h80000000); chk("hold_ready", ready, 1); chk("hold_count", count, 3);

        run_op(32'hC0000000, 32'h80000000, lat, nb, r0, d0);
        chk("b2b_acc_ready", r0, 0); chk("b2b_lat", lat, 4); chk("b2b_q", q, 32'hC0000000);
        run_op(32'hFFFFFFFF, 32'h80000000, lat, nb, r0, d0);
        chk("max_q", q, 32'hFFFFFFFF);
        run_op(32'hA5A5A5A5, 32'h80000000, lat, nb, r0, d0);
        chk("half_q", q, 32'hA5A5A5A5);
        run_op(32'h80000000, 32'hC0000000, lat, nb, r0, d0);
        chk_near("third_q", q, 32'h55555555, 1);
        run_op(32'h80000000, 32'hFFFFFFFF, lat, nb, r0, d0);
        chk_near("bmax_q", q, 32'h40000000, 2);

        run_op(32'h80000000, 32'h00000000, lat, nb, r0, d0);
        chk("dbz0_lat", lat, 0); chk("dbz0_busy", nb, 0); chk("dbz0_flag", dbz, 1);
        chk("dbz0_q", q, 32'hFFFFFFFF); chk("dbz0_count", count, 0);
        @(negedge clk);
        chk("dbz0_hold_busy", busy, 0); chk("dbz0_hold_ready", ready, 1);
        run_op(32'h80000000, 32'h7FFFFFFF, lat, nb, r0, d0);
        chk("dbz1_lat", lat, 0); chk("dbz1_busy", nb, 0); chk("dbz1_flag", dbz, 1);
        chk("dbz1_q", q, 32'hFFFFFFFF);
        run_op(32'hC0000000, 32'h80000000, lat, nb, r0, d0);
        chk("after_dbz_acc_dbz", d0, 0); chk("after_dbz_acc_ready", r0, 0);
        chk("after_dbz_q", q, 32'hC0000000); chk("after_dbz_flag", dbz, 0);

        @(negedge clk);
        a = 32'h80000000; b = 32'h80000000; start = 1'b1;
        @(posedge clk);
        #1 a = 32'hC0000000; b = 32'hC0000000;
        repeat (4) @(posedge clk);
        #1 start = 1'b0;
        chk("held_ready", ready, 1); chk("held_q", q, 32'h80000000); chk("held_count", count, 3);
        run_op(32'hC0000000, 32'h80000000, lat, nb, r0, d0);
        chk("held_next_lat", lat, 4); chk("held_next_q", q, 32'hC0000000);

        @(negedge clk);
        a = 32'h80000000; b = 32'h80000000; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #3 clrn = 1'b0;
        #1;
        chk("mid_rst_q", q, 0); chk("mid_rst_busy", busy, 0); chk("mid_rst_ready", ready, 0);
        chk("mid_rst_dbz", dbz, 0); chk("mid_rst_count", count, 0);
        @(negedge clk) clrn = 1'b1;
        seen = 1'b0;
        repeat (8) @(negedge clk) if (ready !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        chk("mid_rst_quiet", seen, 0);
        run_op(32'hA5A5A5A5, 32'h80000000, lat, nb, r0, d0);
        chk("post_rst_lat", lat, 4); chk("post_rst_q", q, 32'hA5A5A5A5);

        for (int i = 0; i < 300; i++) begin
            ra = $urandom | 32'h80000000;
            rb = $urandom | 32'h80000000;
            run_op(ra, rb, lat, nb, r0, d0);
            ref_q = ({32'h0, ra} << 31) / {32'h0, rb};
            chk("rand_lat", lat, 4);
            chk_near("rand_q", q, ref_q[31:0], 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
